// File: rtl/blink_monitor.sv
// blink_monitor: measures the flg-to-flg interval of an upstream blinker,
// locks after LOCK_CNT consecutive intervals equal to EXP_PERIOD, and
// records the first fault (timeout, period mismatch or LED toggle fault).
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   flg          one-cycle marker pulse from the blinker
//   led          blinker LED level
//   period       last measured flg-to-flg interval in clk cycles
//   period_vld   one-cycle strobe, period updated this cycle
//   locked       high while LOCK_CNT consecutive intervals matched
//   err          sticky error flag
//   err_code     first error: 01 timeout, 10 period mismatch, 11 LED fault
module blink_monitor #(
    parameter int PBITS      = 12,
    parameter int EXP_PERIOD = 2048,
    parameter int LOCK_CNT   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flg,
    input  logic             led,
    output logic [PBITS-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             err,
    output logic [1:0]       err_code
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [PBITS-1:0] TMAX = '1;

    typedef enum logic [1:0] {WAIT_FIRST, MEASURE, LOCKED} state_t;

    state_t           r_state;
    logic [PBITS-1:0] r_timer;
    logic [PBITS-1:0] r_period;
    logic [MW-1:0]    r_match;
    logic [1:0]       r_tog;
    logic             r_led_q;
    logic             r_vld;
    logic             r_locked;
    logic             r_err;
    logic [1:0]       r_code;

    logic             w_tog;
    logic [1:0]       w_tog_sum;
    logic [PBITS-1:0] w_meas;
    logic             w_pm;
    logic             w_lf;
    logic             w_to;
    logic             w_lock;

    assign w_tog     = led ^ r_led_q;
    assign w_tog_sum = (r_tog == 2'd3) ? 2'd3 : r_tog + {1'b0, w_tog};
    // timer holds cycles since the opening flg minus one, so +1 is the interval
    assign w_meas    = r_timer + 1'b1;
    assign w_pm      = w_meas != PBITS'(EXP_PERIOD);
    // toggle of the closing flg cycle belongs to the next interval, so use r_tog
    assign w_lf      = r_tog != 2'd1;
    // timer is about to reach its maximum without a closing flg
    assign w_to      = !flg && (r_timer == TMAX - 1'b1);
    assign w_lock    = r_match >= MW'(LOCK_CNT - 1);

    assign period     = r_period;
    assign period_vld = r_vld;
    assign locked     = r_locked;
    assign err        = r_err;
    assign err_code   = r_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= WAIT_FIRST;
            r_timer  <= '0;
            r_period <= '0;
            r_match  <= '0;
            r_tog    <= 2'd0;
            r_led_q  <= led;
            r_vld    <= 1'b0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
            r_code   <= 2'b00;
        end else begin
            r_led_q <= led;
            r_vld   <= 1'b0;
            if (r_state == WAIT_FIRST) begin
                r_tog <= flg ? {1'b0, w_tog} : w_tog_sum;
                if (flg) begin
                    r_timer <= '0;
                    r_state <= MEASURE;
                end
            end else if (flg) begin
                r_timer  <= '0;
                r_period <= w_meas;
                r_vld    <= 1'b1;
                r_tog    <= {1'b0, w_tog};
                if (w_pm || w_lf) begin
                    r_match  <= '0;
                    r_state  <= MEASURE;
                    r_locked <= 1'b0;
                    if (!r_err) begin
                        r_err  <= 1'b1;
                        r_code <= w_pm ? 2'b10 : 2'b11;
                    end
                end else begin
                    r_match <= w_lock ? MW'(LOCK_CNT) : r_match + 1'b1;
                    if (w_lock) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                    end
                end
            end else begin
                r_tog   <= w_tog_sum;
                r_timer <= (r_timer == TMAX) ? TMAX : r_timer + 1'b1;
                if (w_to) begin
                    r_match  <= '0;
                    r_state  <= WAIT_FIRST;
                    r_locked <= 1'b0;
                    if (!r_err) begin
                        r_err  <= 1'b1;
                        r_code <= 2'b01;
                    end
                end
            end
        end
    end
endmodule
